// File: rtl/sdram_req_ctrl.sv
// Burst request arbiter between external write/read FIFOs and an SDRAM controller.
// Round-robin grant, burst end on falling edge of ack, ring addressing with reload.
module sdram_req_ctrl #(
    parameter logic [23:0] WR_MIN   = 24'd0,
    parameter logic [23:0] WR_MAX   = 24'd786432,
    parameter logic [23:0] RD_MIN   = 24'd0,
    parameter logic [23:0] RD_MAX   = 24'd786432,
    parameter logic [9:0]  WR_BURST = 10'd512,
    parameter logic [9:0]  RD_BURST = 10'd512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic [9:0]  wr_fifo_used,
    input  logic [9:0]  rd_fifo_used,
    input  logic        wr_load,
    input  logic        rd_load,
    input  logic        read_valid,
    output logic        sdram_wr_req,
    input  logic        sdram_wr_ack,
    output logic [23:0] sdram_wr_addr,
    output logic [9:0]  sdram_wr_burst,
    output logic        sdram_rd_req,
    input  logic        sdram_rd_ack,
    output logic [23:0] sdram_rd_addr,
    output logic [9:0]  sdram_rd_burst,
    output logic        wr_fifo_rden,
    output logic        rd_fifo_wren,
    output logic        wr_wrap
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

    state_e      state_q, state_d;
    logic        wr_req_q, wr_req_d, rd_req_q, rd_req_d;
    logic [23:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic        wr_wrap_q, wr_wrap_d;
    logic        wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic        wr_ack_d1_q, wr_ack_d1_d, rd_ack_d1_q, rd_ack_d1_d;
    logic        last_rd_q, last_rd_d;

    logic        wr_elig, rd_elig, wr_end, rd_end;
    logic [24:0] wr_sum, rd_sum;

    assign wr_elig = (wr_fifo_used >= WR_BURST);
    assign rd_elig = read_valid && (rd_fifo_used < RD_BURST);
    // Ack history only counts while our request is up, so stray acks cannot fake a burst end.
    assign wr_end  = (state_q == WRITE) && wr_req_q && wr_ack_d1_q && !sdram_wr_ack;
    assign rd_end  = (state_q == READ) && rd_req_q && rd_ack_d1_q && !sdram_rd_ack;
    assign wr_sum  = {1'b0, wr_addr_q} + {15'd0, WR_BURST};
    assign rd_sum  = {1'b0, rd_addr_q} + {15'd0, RD_BURST};

    always_comb begin
        state_d     = state_q;
        wr_req_d    = wr_req_q;
        rd_req_d    = rd_req_q;
        last_rd_d   = last_rd_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wr_wrap_d   = 1'b0;
        wr_pend_d   = wr_pend_q;
        rd_pend_d   = rd_pend_q;
        wr_ack_d1_d = sdram_wr_ack & wr_req_q;
        rd_ack_d1_d = sdram_rd_ack & rd_req_q;

        case (state_q)
            IDLE: begin
                if (sdram_init_done) begin
                    if (wr_elig && (!rd_elig || last_rd_q)) begin
                        state_d   = WRITE;
                        wr_req_d  = 1'b1;
                        last_rd_d = 1'b0;
                    end else if (rd_elig) begin
                        state_d   = READ;
                        rd_req_d  = 1'b1;
                        last_rd_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (wr_end) begin
                    state_d  = IDLE;
                    wr_req_d = 1'b0;
                end
            end
            READ: begin
                if (rd_end) begin
                    state_d  = IDLE;
                    rd_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A reload requested during its own burst waits for the burst end and beats the wrap.
        if (wr_end) begin
            wr_pend_d = 1'b0;
            if (wr_load || wr_pend_q) begin
                wr_addr_d = WR_MIN;
            end else if (wr_sum >= {1'b0, WR_MAX}) begin
                wr_addr_d = WR_MIN;
                wr_wrap_d = 1'b1;
            end else begin
                wr_addr_d = wr_sum[23:0];
            end
        end else if (wr_load) begin
            if (state_q == WRITE) wr_pend_d = 1'b1;
            else                  wr_addr_d = WR_MIN;
        end

        if (rd_end) begin
            rd_pend_d = 1'b0;
            if (rd_load || rd_pend_q)          rd_addr_d = RD_MIN;
            else if (rd_sum >= {1'b0, RD_MAX}) rd_addr_d = RD_MIN;
            else                               rd_addr_d = rd_sum[23:0];
        end else if (rd_load) begin
            if (state_q == READ) rd_pend_d = 1'b1;
            else                 rd_addr_d = RD_MIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_addr_q   <= WR_MIN;
            rd_addr_q   <= RD_MIN;
            wr_wrap_q   <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            wr_ack_d1_q <= 1'b0;
            rd_ack_d1_q <= 1'b0;
            last_rd_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_wrap_q   <= wr_wrap_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            wr_ack_d1_q <= wr_ack_d1_d;
            rd_ack_d1_q <= rd_ack_d1_d;
            last_rd_q   <= last_rd_d;
        end
    end

    assign sdram_wr_req   = wr_req_q;
    assign sdram_rd_req   = rd_req_q;
    assign sdram_wr_addr  = wr_addr_q;
    assign sdram_rd_addr  = rd_addr_q;
    assign sdram_wr_burst = WR_BURST;
    assign sdram_rd_burst = RD_BURST;
    assign wr_fifo_rden   = sdram_wr_ack;
    assign rd_fifo_wren   = sdram_rd_ack;
    assign wr_wrap        = wr_wrap_q;

endmodule

// File: tb/tb_sdram_req_ctrl.sv
// Bench for sdram_req_ctrl: directed scenarios then randomized grants against a burst-level model.
module tb_sdram_req_ctrl;

    localparam logic [23:0] WMIN = 24'd0;
    localparam logic [23:0] WMAX = 24'd1024;
    localparam logic [23:0] RMIN = 24'd0;
    localparam logic [23:0] RMAX = 24'd1536;
    localparam logic [9:0]  WB   = 10'd512;
    localparam logic [9:0]  RB   = 10'd512;

    logic        clk, rst_n, sdram_init_done;
    logic [9:0]  wr_fifo_used, rd_fifo_used;
    logic        wr_load, rd_load, read_valid;
    logic        sdram_wr_req, sdram_wr_ack, sdram_rd_req, sdram_rd_ack;
    logic [23:0] sdram_wr_addr, sdram_rd_addr;
    logic [9:0]  sdram_wr_burst, sdram_rd_burst;
    logic        wr_fifo_rden, rd_fifo_wren, wr_wrap;

    int checks = 0;
    int failures = 0;
    logic [24:0] exp_q[$];

    // Burst-level model: next start address per type and who was served last.
    logic [23:0] m_wr_addr, m_rd_addr;
    logic        m_last_rd;

    sdram_req_ctrl #(
        .WR_MIN(WMIN), .WR_MAX(WMAX), .RD_MIN(RMIN), .RD_MAX(RMAX),
        .WR_BURST(WB), .RD_BURST(RB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
        .wr_fifo_used(wr_fifo_used), .rd_fifo_used(rd_fifo_used),
        .wr_load(wr_load), .rd_load(rd_load), .read_valid(read_valid),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack),
        .sdram_wr_addr(sdram_wr_addr), .sdram_wr_burst(sdram_wr_burst),
        .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack),
        .sdram_rd_addr(sdram_rd_addr), .sdram_rd_burst(sdram_rd_burst),
        .wr_fifo_rden(wr_fifo_rden), .rd_fifo_wren(rd_fifo_wren), .wr_wrap(wr_wrap)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] advance(input logic [23:0] a, input logic [9:0] b,
                                            input logic [23:0] mn, input logic [23:0] mx);
        int s;
        s = int'(a) + int'(b);
        return (s >= int'(mx)) ? mn : s[23:0];
    endfunction

    function automatic logic wraps(input logic [23:0] a, input logic [9:0] b, input logic [23:0] mx);
        return (int'(a) + int'(b)) >= int'(mx);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        wr_fifo_used = '0; rd_fifo_used = '0; read_valid = 1'b0;
        wr_load = 1'b0; rd_load = 1'b0; sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        tick();
        tick();
        chk("rst_wr_req", sdram_wr_req, 0);
        chk("rst_rd_req", sdram_rd_req, 0);
        chk("rst_wr_addr", sdram_wr_addr, WMIN);
        chk("rst_rd_addr", sdram_rd_addr, RMIN);
        chk("rst_wr_wrap", wr_wrap, 0);
        chk("wr_burst_len", sdram_wr_burst, WB);
        chk("rd_burst_len", sdram_rd_burst, RB);
        rst_n = 1'b1;
        m_wr_addr = WMIN; m_rd_addr = RMIN; m_last_rd = 1'b1;
        tick();
    endtask

    task automatic wait_req(output logic got_wr, output logic got_rd);
        int n = 0;
        while (!(sdram_wr_req || sdram_rd_req) && n < 3) begin
            tick();
            n++;
        end
        chk("req_within_2", sdram_wr_req | sdram_rd_req, 1);
        got_wr = sdram_wr_req;
        got_rd = sdram_rd_req;
    endtask

    task automatic no_req(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk(tag, {sdram_wr_req, sdram_rd_req}, 2'b00);
        end
    endtask

    // Drive n contiguous acks; load_at==i pulses the own-type load in that ack cycle,
    // load_at==n pulses it in the ack-low (burst end) cycle.
    task automatic run_burst(input logic is_wr, input int n, input int load_at, input logic keep_elig);
        logic [23:0] a0, a_next;
        logic        ld, exp_wrap;
        int          pulses = 0;
        ld = 1'b0;
        a0 = is_wr ? m_wr_addr : m_rd_addr;
        chk("burst_start_addr", is_wr ? sdram_wr_addr : sdram_rd_addr, a0);
        for (int i = 0; i < n; i++) begin
            if (is_wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
            if (i == load_at) begin
                ld = 1'b1;
                if (is_wr) wr_load = 1'b1; else rd_load = 1'b1;
            end
            #1;
            if ((is_wr ? wr_fifo_rden : rd_fifo_wren) === 1'b1) pulses++;
            tick();
            wr_load = 1'b0; rd_load = 1'b0;
            chk("req_held", is_wr ? sdram_wr_req : sdram_rd_req, 1);
            chk("addr_held", is_wr ? sdram_wr_addr : sdram_rd_addr, a0);
        end
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        if (load_at == n) begin
            ld = 1'b1;
            if (is_wr) wr_load = 1'b1; else rd_load = 1'b1;
        end
        if (!keep_elig) begin
            wr_fifo_used = '0;
            read_valid = 1'b0;
        end
        #1;
        chk("strobe_count", pulses, n);
        chk("strobe_low", is_wr ? wr_fifo_rden : rd_fifo_wren, 0);
        tick();
        wr_load = 1'b0; rd_load = 1'b0;
        chk("req_drop", is_wr ? sdram_wr_req : sdram_rd_req, 0);
        if (is_wr) begin
            a_next   = ld ? WMIN : advance(a0, WB, WMIN, WMAX);
            exp_wrap = !ld && wraps(a0, WB, WMAX);
            chk("wr_next_addr", sdram_wr_addr, a_next);
            chk("wr_wrap_pulse", wr_wrap, exp_wrap);
            m_wr_addr = a_next;
        end else begin
            a_next = ld ? RMIN : advance(a0, RB, RMIN, RMAX);
            chk("rd_next_addr", sdram_rd_addr, a_next);
            chk("rd_no_wrap", wr_wrap, 0);
            m_rd_addr = a_next;
        end
        m_last_rd = !is_wr;
        tick();
        chk("wrap_one_cycle", wr_wrap, 0);
    endtask

    task automatic grant_burst(input logic exp_wr, input int n, input int load_at, input logic keep_elig);
        logic gw, gr;
        wait_req(gw, gr);
        chk("grant_is_write", gw, exp_wr);
        chk("grant_single", gw & gr, 0);
        if (gw | gr) run_burst(gw, n, load_at, keep_elig);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic gw, gr;
        logic [9:0]  wfu, rfu;
        logic        rv, wel, rel, pred_wr;
        logic [24:0] e;

        do_reset();

        // No requests before initialisation completes.
        wr_fifo_used = 10'd512; read_valid = 1'b1; rd_fifo_used = 10'd0;
        no_req("no_req_before_init", 5);
        read_valid = 1'b0;

        // Full 512-word write burst, then two more to show ring wrap at 1024.
        sdram_init_done = 1'b1;
        grant_burst(1'b1, 512, 1000, 1'b0);
        chk("wr_addr_after_first", sdram_wr_addr, 24'd512);
        wr_fifo_used = 10'd600;
        grant_burst(1'b1, 512, 1000, 1'b0);
        chk("wr_addr_wrapped", sdram_wr_addr, 24'd0);
        wr_fifo_used = 10'd512;
        grant_burst(1'b1, 512, 1000, 1'b0);
        chk("wr_addr_third", sdram_wr_addr, 24'd512);

        // Reload mid-burst at 512: burst finishes, next start is 0, no wrap pulse.
        wr_fifo_used = 10'd1000;
        grant_burst(1'b1, 40, 10, 1'b0);
        chk("wr_reload_addr", sdram_wr_addr, 24'd0);

        // Read gated by FIFO fill level.
        read_valid = 1'b1; rd_fifo_used = 10'd600;
        no_req("rd_blocked_full", 5);
        rd_fifo_used = 10'd100;
        grant_burst(1'b0, 16, 1000, 1'b0);
        chk("rd_addr_after", sdram_rd_addr, 24'd512);

        // Stray acks while idle reach the FIFO strobes but change nothing else.
        sdram_wr_ack = 1'b1; sdram_rd_ack = 1'b1;
        #1;
        chk("stray_wr_strobe", wr_fifo_rden, 1);
        chk("stray_rd_strobe", rd_fifo_wren, 1);
        tick();
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        no_req("stray_no_req", 3);
        chk("stray_wr_addr", sdram_wr_addr, m_wr_addr);
        chk("stray_rd_addr", sdram_rd_addr, m_rd_addr);

        // Reload while idle takes effect on the next edge.
        rd_load = 1'b1;
        tick();
        rd_load = 1'b0;
        chk("rd_load_idle", sdram_rd_addr, RMIN);
        m_rd_addr = RMIN;

        // Reload coinciding with burst end wins over the normal advance.
        wr_fifo_used = 10'd512;
        grant_burst(1'b1, 8, 8, 1'b0);
        chk("load_at_end", sdram_wr_addr, WMIN);

        // Init dropping mid-burst: burst completes, then idle holds.
        wr_fifo_used = 10'd512;
        wait_req(gw, gr);
        chk("init_drop_grant", gw, 1);
        sdram_init_done = 1'b0;
        if (gw) run_burst(1'b1, 8, 1000, 1'b1);
        no_req("init_low_hold", 4);
        sdram_init_done = 1'b1;
        grant_burst(1'b1, 4, 1000, 1'b0);

        // Round-robin alternation from reset with both types eligible.
        do_reset();
        sdram_init_done = 1'b1;
        wr_fifo_used = 10'd512; read_valid = 1'b1; rd_fifo_used = 10'd0;
        for (int k = 0; k < 4; k++) begin
            grant_burst((k % 2) == 0, 6, 1000, k < 3);
        end

        // Reset in the middle of a read burst.
        read_valid = 1'b1; rd_fifo_used = 10'd0; wr_fifo_used = 10'd0;
        wait_req(gw, gr);
        chk("pre_reset_rd_grant", gr, 1);
        chk("pre_reset_rd_addr", sdram_rd_addr, m_rd_addr);
        sdram_rd_ack = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_drops_rd_req", sdram_rd_req, 0);
        chk("reset_rd_addr", sdram_rd_addr, RMIN);
        sdram_rd_ack = 1'b0;
        sdram_init_done = 1'b0;
        tick();
        rst_n = 1'b1;
        m_wr_addr = WMIN; m_rd_addr = RMIN; m_last_rd = 1'b1;
        no_req("post_reset_init_low", 5);
        read_valid = 1'b0;
        sdram_init_done = 1'b1;
        tick();

        // Randomized eligibility against the burst-level model.
        for (int it = 0; it < 40; it++) begin
            wfu = 10'($urandom_range(0, 1023));
            rfu = 10'($urandom_range(0, 1023));
            rv  = 1'($urandom_range(0, 1));
            wel = (wfu >= WB);
            rel = rv && (rfu < RB);
            wr_fifo_used = wfu; rd_fifo_used = rfu; read_valid = rv;
            if (!wel && !rel) begin
                no_req("rand_no_eligible", 2);
                continue;
            end
            pred_wr = wel && (!rel || m_last_rd);
            exp_q.push_back({pred_wr, pred_wr ? m_wr_addr : m_rd_addr});
            wait_req(gw, gr);
            e = exp_q.pop_front();
            chk("rand_grant_type", gw, e[24]);
            chk("rand_grant_addr", gw ? sdram_wr_addr : sdram_rd_addr, e[23:0]);
            if (gw | gr) run_burst(gw, $urandom_range(1, 24), $urandom_range(0, 40), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
